// File: rtl/ram_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : ram_rd_streamer
// Description : Read-side streaming engine for the 4096 x 64 dual-port RAM.
//               Turns a (start address, length) command into sequential RAM
//               reads, absorbs the fixed RAM read latency and delivers the
//               words as a valid/ready stream with a last-beat flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_rd_streamer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic                  ram_read,
    output logic [ADDR_WIDTH-1:0] ram_rd_address,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    // One extra bit so occupancy + inflight can never wrap in the compare
    localparam int c_SUM_W = c_CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_remaining;

    // In-flight read tracking: bit 0 is the newest issue, MSB is the exit stage
    logic [RD_LATENCY-1:0]   r_pipe_vld;
    logic [RD_LATENCY-1:0]   r_pipe_last;

    logic [DATA_WIDTH-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   r_fifo_last;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_occupancy;

    logic [c_CNT_W-1:0]      w_inflight;
    logic [c_SUM_W-1:0]      w_level;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_empty;
    logic                    w_full;

    // Count of valid in-flight stages
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + c_CNT_W'(r_pipe_vld[i]);
        end
    end

    // Issue decision uses registered counts only; a same-cycle pop is not credited
    assign w_level      = {1'b0, r_occupancy} + {1'b0, w_inflight};
    assign w_issue      = (r_state == ST_ISSUE) && (w_level < c_SUM_W'(FIFO_DEPTH));
    assign w_issue_last = w_issue && (r_remaining == '0);

    assign w_empty      = (r_occupancy == '0);
    assign w_full       = (r_occupancy == c_CNT_W'(FIFO_DEPTH));
    assign w_push       = r_pipe_vld[RD_LATENCY-1];
    assign w_pop        = !w_empty && m_ready;

    assign ram_read       = w_issue;
    assign ram_rd_address = r_addr;
    assign cmd_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign m_valid        = !w_empty;
    // Head is gated so stale buffer contents never show while empty
    assign m_data         = w_empty ? '0 : r_fifo_data[r_rd_ptr];
    assign m_last         = !w_empty && r_fifo_last[r_rd_ptr];

    // Command FSM: latches the command, walks the address and length counters
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_remaining <= cmd_len;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - ADDR_WIDTH'(1);
                        if (r_remaining == '0) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && m_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Latency-matching shift register of {valid, last} per issued read
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else begin
            r_pipe_vld  <= (r_pipe_vld << 1)  | RD_LATENCY'(w_issue);
            r_pipe_last <= (r_pipe_last << 1) | RD_LATENCY'(w_issue_last);
        end
    end

    // Output buffer storage; pointers are flushed by reset so contents need none
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ram_data_out;
            r_fifo_last[r_wr_ptr] <= r_pipe_last[RD_LATENCY-1];
        end
    end

    // Output buffer pointers and occupancy
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occupancy <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occupancy <= r_occupancy + c_CNT_W'(1);
                2'b01:   r_occupancy <= r_occupancy - c_CNT_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase
        end
    end

    // The issue throttle guarantees a returning word always has a free slot
    a_fifo_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
        !(w_push && w_full));

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_rd_streamer
// Description : Self-checking bench for ram_rd_streamer with a behavioural
//               RAM and scoreboard queues for read addresses and output beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_rd_streamer;

    localparam int DW = 64;
    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          ram_read;
    logic [AW-1:0] ram_rd_address;
    logic [DW-1:0] ram_data_out = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    ram_rd_streamer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .RD_LATENCY(1)
    ) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_read(ram_read), .ram_rd_address(ram_rd_address),
        .ram_data_out(ram_data_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int pop_count = 0;
    int last_count = 0;
    int issue_count = 0;

    logic [DW-1:0] mem [0:4095];
    logic [AW-1:0] addr_q [$];
    logic [DW:0]   exp_q  [$];
    logic [AW-1:0] mon_a;
    logic [DW:0]   mon_e;

    // Behavioural RAM with one cycle read latency
    always @(posedge clock) begin
        if (ram_read) ram_data_out <= mem[ram_rd_address];
    end

    // Scoreboard monitor: read addresses and output beats, sampled mid-cycle
    always @(negedge clock) begin
        if (resetn) begin
            if (ram_read === 1'b1) begin
                issue_count++;
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr: unexpected issue at %h, none required", ram_rd_address);
                end else begin
                    mon_a = addr_q.pop_front();
                    if (ram_rd_address !== mon_a) begin
                        errors++;
                        $display("FAIL rd_addr: got %h required %h", ram_rd_address, mon_a);
                    end
                end
            end
            if (m_valid === 1'b1 && m_ready) begin
                pop_count++;
                if (m_last) last_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected beat %h last=%b", m_data, m_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_last, m_data} !== mon_e) begin
                        errors++;
                        $display("FAIL beat: got last=%b data=%h required last=%b data=%h",
                                 m_last, m_data, mon_e[DW], mon_e[DW-1:0]);
                    end
                end
            end
        end
    end

    task automatic push_expected(input logic [AW-1:0] a0, input int len);
        logic [AW-1:0] a;
        for (int i = 0; i <= len; i++) begin
            a = a0 + i[AW-1:0];
            addr_q.push_back(a);
            exp_q.push_back({(i == len), mem[a]});
        end
    endtask

    // Presents a command for one cycle; returns #1 into the cycle after acceptance
    task automatic send_cmd(input logic [AW-1:0] a0, input int len);
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_addr  = a0;
        cmd_len   = len[AW-1:0];
        push_expected(a0, len);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetn    = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = 12'h005;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({cmd_ready, ram_read, ram_rd_address, m_valid, m_data, m_last, busy} !==
            {1'b1, 1'b0, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: cr=%b rd=%b ra=%h mv=%b md=%h ml=%b busy=%b required 1 0 000 0 0 0 0",
                     cmd_ready, ram_read, ram_rd_address, m_valid, m_data, m_last, busy);
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        resetn    = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || ram_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ignored: busy=%b rd=%b required 0 0", busy, ram_read);
        end
    endtask

    task automatic test_single_word;
        m_ready = 1'b1;
        mem[12'h010] = 64'hA5A5_0000_0000_0001;
        send_cmd(12'h010, 0);
        @(negedge clock);   // T+1
        checks++;
        if (ram_read !== 1'b1 || ram_rd_address !== 12'h010) begin
            errors++;
            $display("FAIL single_issue: rd=%b ra=%h required 1 010", ram_read, ram_rd_address);
        end
        @(negedge clock);   // T+2
        checks++;
        if (ram_read !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t2: rd=%b mv=%b required 0 0", ram_read, m_valid);
        end
        @(negedge clock);   // T+3
        checks++;
        if ({m_valid, m_last, m_data, cmd_ready} !== {1'b1, 1'b1, 64'hA5A5_0000_0000_0001, 1'b0}) begin
            errors++;
            $display("FAIL single_t3: mv=%b ml=%b md=%h cr=%b required 1 1 a5a5000000000001 0",
                     m_valid, m_last, m_data, cmd_ready);
        end
        @(negedge clock);   // T+4
        checks++;
        if (cmd_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t4: cr=%b mv=%b required 1 0", cmd_ready, m_valid);
        end
    endtask

    task automatic test_streaming;
        logic exp_rd, exp_mv, exp_cr;
        m_ready = 1'b1;
        send_cmd(12'h100, 7);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            exp_rd = (k <= 8);
            exp_mv = (k >= 3) && (k <= 10);
            exp_cr = (k == 11);
            checks++;
            if ({ram_read, m_valid, cmd_ready} !== {exp_rd, exp_mv, exp_cr}) begin
                errors++;
                $display("FAIL stream_T+%0d: rd/mv/cr=%b%b%b required %b%b%b",
                         k, ram_read, m_valid, cmd_ready, exp_rd, exp_mv, exp_cr);
            end
        end
    endtask

    task automatic test_wrap;
        bit ok;
        m_ready = 1'b1;
        send_cmd(12'hFFE, 3);
        wait_idle(50, ok);
        checks++;
        if (!ok || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_done: idle=%b beats_left=%0d addrs_left=%0d required 1 0 0",
                     ok, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int base_iss, base_pop;
        m_ready  = 1'b0;
        base_iss = issue_count;
        base_pop = pop_count;
        send_cmd(12'h200, 15);
        repeat (10) @(negedge clock);
        checks++;
        if (issue_count - base_iss != 4) begin
            errors++;
            $display("FAIL bp_stall_issues: got %0d required 4", issue_count - base_iss);
        end
        checks++;
        if (m_valid !== 1'b1 || ram_read !== 1'b0) begin
            errors++;
            $display("FAIL bp_stalled: mv=%b rd=%b required 1 0", m_valid, ram_read);
        end
        @(posedge clock); #1;
        m_ready = 1'b1;
        wait_idle(100, ok);
        checks++;
        if (!ok || pop_count - base_pop != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_done: idle=%b beats=%0d left=%0d required 1 16 0",
                     ok, pop_count - base_pop, exp_q.size());
        end
    endtask

    task automatic test_reset_midop;
        bit ok;
        int base_pop;
        m_ready  = 1'b1;
        base_pop = pop_count;
        send_cmd(12'h300, 15);
        for (int i = 0; i < 50 && (pop_count - base_pop) < 3; i++) @(negedge clock);
        @(posedge clock); #1;
        resetn = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(posedge clock); #1;
        resetn = 1'b1;
        @(negedge clock);
        checks++;
        if ({cmd_ready, ram_read, ram_rd_address, m_valid, m_data, m_last, busy} !==
            {1'b1, 1'b0, 12'h000, 1'b0, 64'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midop_reset_values: cr=%b rd=%b ra=%h mv=%b md=%h ml=%b busy=%b required 1 0 000 0 0 0 0",
                     cmd_ready, ram_read, ram_rd_address, m_valid, m_data, m_last, busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midop_quiet: mv=%b busy=%b required 0 0", m_valid, busy);
            end
        end
        send_cmd(12'h400, 5);
        wait_idle(50, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midop_restream: idle=%b left=%0d required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int acc_k;
        m_ready = 1'b1;
        send_cmd(12'h500, 3);
        cmd_valid = 1'b1;
        cmd_addr  = 12'h600;
        cmd_len   = 12'd2;
        push_expected(12'h600, 2);
        acc_k = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (cmd_ready === 1'b1) begin
                acc_k = k;
                break;
            end
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        checks++;
        if (acc_k != 7) begin
            errors++;
            $display("FAIL b2b_accept_cycle: got T+%0d required T+7", acc_k);
        end
        @(negedge clock);
        checks++;
        if (ram_read !== 1'b1 || ram_rd_address !== 12'h600) begin
            errors++;
            $display("FAIL b2b_first_issue: rd=%b ra=%h required 1 600", ram_read, ram_rd_address);
        end
        wait_idle(50, ok);
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done: idle=%b left=%0d required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_full_length;
        bit ok;
        int base_pop, base_last;
        base_pop  = pop_count;
        base_last = last_count;
        m_ready   = 1'b1;
        send_cmd(12'h123, 4095);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clock); #1;
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        checks++;
        if (!ok || pop_count - base_pop != 4096 || last_count - base_last != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_length: idle=%b beats=%0d lasts=%0d left=%0d required 1 4096 1 0",
                     ok, pop_count - base_pop, last_count - base_last, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 64'(i);
        test_reset;
        test_single_word;
        test_streaming;
        test_wrap;
        test_backpressure;
        test_reset_midop;
        test_back_to_back;
        test_full_length;
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ram_rd_streamer.md
# ram_rd_streamer

Read-side streaming engine for the 4096 x 64 dual-port RAM. It accepts a (start address, length) command and issues sequential reads on the RAM read port (`read`, `rd_address`). It absorbs the RAM's fixed read latency and delivers the words as a valid/ready stream with a last-beat flag. It sits directly downstream of the RAM read port and is the consumer of `data_out`.

## Interface

Parameters:
- `DATA_WIDTH`, 64: RAM word width.
- `ADDR_WIDTH`, 12: RAM address width (4096 words).
- `FIFO_DEPTH`, 4: output buffer entries; power of two, at least `RD_LATENCY`+2.
- `RD_LATENCY`, 1: cycles from a sampled `ram_read` to valid `ram_data_out`; legal values 1..2.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block can accept a command (IDLE only).
- `cmd_addr` in `ADDR_WIDTH`: first word address.
- `cmd_len` in `ADDR_WIDTH`: word count minus 1 (0 means 1 word, 4095 means 4096 words).
- `ram_read` out 1: read strobe to the RAM read port.
- `ram_rd_address` out `ADDR_WIDTH`: read address to the RAM.
- `ram_data_out` in `DATA_WIDTH`: RAM read data.
- `m_valid` out 1: output word available.
- `m_ready` in 1: downstream accepts the word.
- `m_data` out `DATA_WIDTH`: output word.
- `m_last` out 1: final word of the current command.
- `busy` out 1: state is not IDLE.

## Operation

- FSM has three states: IDLE, ISSUE, DRAIN. Reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch `addr`=`cmd_addr` and `remaining`=`cmd_len`, then go to ISSUE.
- ISSUE:
  - `ram_read`=1 in any cycle where `occupancy + inflight < FIFO_DEPTH`. Both terms are registered values, and a same-cycle pop is not counted as freeing space.
  - `ram_rd_address`=`addr`.
  - Each issue increments `addr` modulo 2^`ADDR_WIDTH` (4095 wraps to 0) and decrements `remaining`.
  - The issue made when `remaining`==0 carries the last tag and moves the FSM to DRAIN.
- In-flight tracking:
  - Each issue enters a `RD_LATENCY`-deep shift register of {valid, last}.
  - At its exit stage, `ram_data_out` and the last tag are written into the FIFO.
  - `inflight` is the count of valid stages (0..`RD_LATENCY`).
- DRAIN:
  - No issues.
  - Go to IDLE in the cycle after the last-tagged word pops (`m_valid && m_ready && m_last`).
- Output side:
  - `m_valid` = FIFO not empty.
  - `m_data` and `m_last` come from the FIFO head.
  - A pop occurs on `m_valid && m_ready`.
  - The FIFO never overflows by construction. A push into a full FIFO is an assertion failure.
  - Simultaneous push and pop leaves occupancy unchanged.
- `busy` = (state != IDLE).
- While not IDLE, new commands are not accepted (`cmd_ready`=0). Commands are never queued.
- Reset mid-operation:
  - FIFO and in-flight stages are flushed and the FSM returns to IDLE.
  - RAM data still returning after reset is discarded.

## Timing

- Reset values:
  - `cmd_ready`=1 (IDLE).
  - `ram_read`=0, `ram_rd_address`=0.
  - `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0.
  - `occupancy`=0, `inflight`=0.
  - A command presented while `resetn`=0 is ignored.
- `ram_read` and `ram_rd_address` are combinational from registered state and counters. They are never driven from `m_ready` or `cmd_valid`.
- Command accepted in cycle T:
  - First `ram_read` in T+1.
  - Data on `ram_data_out` in T+1+`RD_LATENCY`.
  - First `m_valid` in T+2+`RD_LATENCY` (T+3 at default).
- With `m_ready` held at 1, sustained throughput is 1 word per cycle. An N-word command returns to IDLE (`cmd_ready`=1) at T+N+`RD_LATENCY`+2.
- With `m_ready`=0, issues stop once `occupancy + inflight` = `FIFO_DEPTH`. After `m_ready` rises, issuing resumes one cycle after the first pop.
- Back-to-back commands: the next command is accepted in the first IDLE cycle; there is no bubble beyond that.

## Test plan

- Single word: `cmd_addr`=0x010, `cmd_len`=0, RAM[0x010]=0xA5A5_0000_0000_0001 → one `ram_read` at 0x010 in T+1; `m_valid`, `m_last`=1, and that data in T+3; `cmd_ready`=1 at T+4.
- Streaming: `cmd_addr`=0x100, `cmd_len`=7, `m_ready`=1, RAM[a]=a → 8 consecutive issues 0x100..0x107; outputs 0x100..0x107 on consecutive cycles from T+3; `m_last` only on 0x107.
- Wrap-around: `cmd_addr`=0xFFE, `cmd_len`=3 → addresses 0xFFE, 0xFFF, 0x000, 0x001, data in that order.
- Backpressure: `cmd_len`=15, `m_ready`=0 for 10 cycles then 1 → exactly 4 issues before the stall; no lost, duplicated or reordered words; all 16 words delivered.
- Reset mid-op: assert `resetn`=0 for 1 cycle after 3 words are delivered from a 16-word command → all outputs at reset values next cycle; `m_valid` stays 0; a new command then streams correctly.
- Full length: `cmd_len`=4095, `m_ready` random 50% → 4096 words, every address exactly once, single `m_last`.
